// File: rtl/wdb_access_sched.sv
// WDB SRAM port scheduler: drain request queue, read/fill arbitration
// with fill anti-starvation, and per-entry occupancy tracking.
module wdb_access_sched #(
  parameter  int ENTRY_NUM  = 32,
  parameter  int TAG_W      = 6,
  parameter  int RQ_DEPTH   = 4,
  parameter  int STARVE_MAX = 4,
  localparam int ID_W       = $clog2(ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fill_vld_i,
  input  logic [ID_W-1:0]      fill_id_i,
  output logic                 fill_rdy_o,
  input  logic                 drain_vld_i,
  input  logic [ID_W-1:0]      drain_id_i,
  input  logic [TAG_W-1:0]     drain_tag_i,
  output logic                 drain_rdy_o,
  output logic                 mem_en_o,
  output logic                 mem_wr_en_o,
  output logic [ID_W-1:0]      mem_addr_o,
  output logic                 rd_vld_o,
  output logic [ID_W-1:0]      rd_id_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [ENTRY_NUM-1:0] entry_full_o,
  output logic [ID_W:0]        free_cnt_o
);

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [ID_W-1:0]      qid_q  [RQ_DEPTH];
  logic [TAG_W-1:0]     qtag_q [RQ_DEPTH];
  logic [PW:0]          wptr_q, rptr_q;
  logic [SW-1:0]        starve_q, starve_d;
  logic [ENTRY_NUM-1:0] full_q, full_d;
  logic [ID_W:0]        free_q, free_d;
  logic                 rd_vld_q;
  logic [ID_W-1:0]      rd_id_q;
  logic [TAG_W-1:0]     rd_tag_q;

  logic            q_empty, q_full, push;
  logic [ID_W-1:0] head_id;
  logic [TAG_W-1:0] head_tag;
  logic            rd_elig, fill_elig;
  logic            fill_gnt, rd_gnt;

  assign q_empty  = (wptr_q == rptr_q);
  assign q_full   = ((wptr_q - rptr_q) == (PW+1)'(RQ_DEPTH));
  assign head_id  = qid_q[rptr_q[PW-1:0]];
  assign head_tag = qtag_q[rptr_q[PW-1:0]];
  assign push     = drain_vld_i && !q_full;

  assign rd_elig   = !q_empty && full_q[head_id];
  assign fill_elig = rst_n && fill_vld_i && !full_q[fill_id_i];

  // Starved fill takes priority over reads; otherwise reads first.
  assign fill_gnt = fill_elig &&
                    (starve_q == SW'(STARVE_MAX) || !rd_elig);
  assign rd_gnt   = rst_n && rd_elig && !fill_gnt;

  assign fill_rdy_o   = fill_gnt;
  assign drain_rdy_o  = !q_full;
  assign mem_en_o     = fill_gnt || rd_gnt;
  assign mem_wr_en_o  = fill_gnt;
  assign mem_addr_o   = fill_gnt ? fill_id_i : head_id;
  assign rd_vld_o     = rd_vld_q;
  assign rd_id_o      = rd_id_q;
  assign rd_tag_o     = rd_tag_q;
  assign entry_full_o = full_q;
  assign free_cnt_o   = free_q;

  always_comb begin
    starve_d = starve_q;
    if (!fill_vld_i || fill_gnt)
      starve_d = '0;
    else if (fill_elig && rd_gnt &&
             starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    full_d = full_q;
    if (fill_gnt) full_d[fill_id_i] = 1'b1;
    if (rd_gnt)   full_d[head_id]   = 1'b0;
    free_d = free_q - (ID_W+1)'(fill_gnt)
                    + (ID_W+1)'(rd_gnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      starve_q <= '0;
      full_q   <= '0;
      free_q   <= (ID_W+1)'(ENTRY_NUM);
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
      rd_tag_q <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        qid_q[i]  <= '0;
        qtag_q[i] <= '0;
      end
    end else begin
      starve_q <= starve_d;
      full_q   <= full_d;
      free_q   <= free_d;
      rd_vld_q <= rd_gnt;
      if (push) begin
        qid_q[wptr_q[PW-1:0]]  <= drain_id_i;
        qtag_q[wptr_q[PW-1:0]] <= drain_tag_i;
        wptr_q <= wptr_q + (PW+1)'(1);
      end
      if (rd_gnt) begin
        rptr_q   <= rptr_q + (PW+1)'(1);
        rd_id_q  <= head_id;
        rd_tag_q <= head_tag;
      end
    end
  end

endmodule

// File: doc/wdb_access_sched.md
# wdb_access_sched

Scheduler for the single-port write data buffer (WDB) SRAM in the vector cache write path. It shares the one SRAM port between two requesters. Upstream fills write line data into a pre-allocated WDB entry. Drain requests from the dataram write arbiter read an entry out toward the data SRAM. The block queues drain requests, orders them against fills with read priority plus a fill anti-starvation limit, and tracks per-entry occupancy so a drain never reads an empty entry and a fill never overwrites unread data.

## Interface
Parameters:
- ENTRY_NUM, 32, number of WDB entries; ID_W = $clog2(ENTRY_NUM).
- TAG_W, 6, width of the ROB tag carried with a drain.
- RQ_DEPTH, 4, drain request queue depth (power of 2, ≥2).
- STARVE_MAX, 4, max consecutive cycles a pending fill may lose arbitration.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fill_vld  in  1  upstream fill request.
- fill_id  in  ID_W  target entry of fill.
- fill_rdy  out  1  fill granted this cycle (combinational from fill_vld/state).
- drain_vld  in  1  drain request from dataram write arbiter.
- drain_id  in  ID_W  entry to read.
- drain_tag  in  TAG_W  ROB tag, returned with read data.
- drain_rdy  out  1  drain queue not full (registered state only).
- mem_en  out  1  SRAM enable.
- mem_wr_en  out  1  1 = fill write, 0 = drain read.
- mem_addr  out  ID_W  SRAM entry address.
- rd_vld  out  1  SRAM read data valid this cycle; downstream always accepts.
- rd_id  out  ID_W  entry of returned data.
- rd_tag  out  TAG_W  tag of returned data.
- entry_full  out  ENTRY_NUM  occupancy bitmap (1 = holds unread data).
- free_cnt  out  ID_W+1  ENTRY_NUM minus popcount(entry_full).

## Operation
- Drain queue: FIFO of {id, tag}, RQ_DEPTH deep. Push on drain_vld && drain_rdy. Pop on read grant. Strictly in order; the head blocks later drains.
- Read eligible: queue non-empty && entry_full[head.id].
- Fill eligible: fill_vld && !entry_full[fill_id].
- Arbitration, one grant per cycle:
  - Fill wins if fill eligible and starve_cnt == STARVE_MAX.
  - Otherwise read wins if read eligible.
  - Otherwise fill wins if fill eligible.
  - Otherwise idle.
- starve_cnt, saturating at STARVE_MAX:
  - Cleared on fill grant or when fill_vld is 0.
  - +1 on each cycle where fill is eligible but read is granted.
  - Unchanged while fill_vld is 1 but fill is ineligible (entry full).
- Grant outputs:
  - Fill grant: fill_rdy=1, mem_en=1, mem_wr_en=1, mem_addr=fill_id; entry_full[fill_id] set next cycle.
  - Read grant: mem_en=1, mem_wr_en=0, mem_addr=head.id; queue pops; entry_full[head.id] cleared next cycle.
- Set and clear never target the same entry in one cycle: single grant, and a fill to a full entry is ineligible.
- Fill to an occupied entry is held off (fill_rdy=0) until that entry drains. Upstream keeps fill_vld/fill_id stable while waiting.
- Drain whose entry is empty waits at the head. A subsequent fill to that entry makes it eligible.
- Simultaneous push to a full queue and pop: drain_rdy is registered-based, so no push is accepted while full, even in a pop cycle.

## Timing
- Reset values: entry_full=0, free_cnt=ENTRY_NUM, queue empty, starve_cnt=0, drain_rdy=1, rd_vld=0, rd_id=0, rd_tag=0. mem_en=0 and fill_rdy=0 while in reset.
- Drain accepted in cycle N: earliest read grant N+1; rd_vld/rd_id/rd_tag in N+2 (1-cycle SRAM latency, registered copy of the read grant).
- Fill: grant is same cycle as fill_vld when eligible and not blocked. The entry is drain-eligible from the next cycle.
- entry_full and free_cnt are registered; they reflect grants from the previous cycle.
- Throughput: one SRAM access per cycle. Back-to-back reads give rd_vld every cycle.
- Reset mid-operation: queue, bitmap, counter and rd pipeline are cleared immediately. In-flight rd_vld is dropped.

## Test plan
- Reset release, then fill id=3 in cycle 0 -> fill_rdy=1, mem_wr_en=1, mem_addr=3; cycle 1 entry_full[3]=1, free_cnt=31.
- Drain id=3 tag=5 pushed at cycle 2, entry 3 full -> read grant cycle 3 with mem_addr=3, mem_wr_en=0; cycle 4 rd_vld=1, rd_id=3, rd_tag=5, entry_full[3]=0.
- Drain id=7 pushed before any fill to 7 -> no read; fill id=7 granted at cycle K -> read grant K+1, rd_vld K+2.
- Entries 0..5 full, six drains queued, fill_vld held on id=9 -> 4 reads granted, fill granted on 5th cycle (STARVE_MAX=4), then remaining reads.
- Five drains pushed with no fills -> drain_rdy=0 after 4th push; 5th held until a pop occurs.
- Fill to full entry 2 while drain of 2 is queued -> fill_rdy=0 until read of 2 granted; fill granted the cycle after.
